// File: rtl/control_unit_pkg.sv
// Shared decode constants, FSM state encoding and instruction classifier for control_unit.
package riscv_ctrl_pkg;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_OP    = 7'b0110011;

  localparam logic [2:0] F3_LD_SD = 3'b011;
  localparam logic [2:0] F3_ADD   = 3'b000;
  localparam logic [6:0] F7_ADD   = 7'b0000000;
  localparam logic [6:0] F7_SUB   = 7'b0100000;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;

  localparam logic MUX0_RF_A = 1'b0;
  localparam logic MUX0_RF_B = 1'b1;
  localparam logic MUX1_IMM  = 1'b0;
  localparam logic MUX1_RF_B = 1'b1;
  localparam logic MUX2_ALU  = 1'b0;
  localparam logic MUX2_DM   = 1'b1;

  typedef enum logic [2:0] {
    ST_FETCH     = 3'd0,
    ST_DECODE    = 3'd1,
    ST_EXECUTE   = 3'd2,
    ST_MEM       = 3'd3,
    ST_WRITEBACK = 3'd4
  } cu_state_e;

  typedef enum logic [1:0] {
    IMM_NONE = 2'd0,
    IMM_I    = 2'd1,
    IMM_S    = 2'd2
  } imm_fmt_e;

  typedef enum logic [2:0] {
    OP_ILLEGAL = 3'd0,
    OP_LD      = 3'd1,
    OP_SD      = 3'd2,
    OP_ADDI    = 3'd3,
    OP_ADD     = 3'd4,
    OP_SUB     = 3'd5
  } op_kind_e;

  function automatic op_kind_e classify(input logic [31:0] instr);
    op_kind_e k;
    k = OP_ILLEGAL;
    case (instr[6:0])
      OPC_LOAD:  k = (instr[14:12] == F3_LD_SD) ? OP_LD : OP_ILLEGAL;
      OPC_STORE: k = (instr[14:12] == F3_LD_SD) ? OP_SD : OP_ILLEGAL;
      OPC_OPIMM: k = (instr[14:12] == F3_ADD) ? OP_ADDI : OP_ILLEGAL;
      OPC_OP: begin
        if (instr[14:12] == F3_ADD && instr[31:25] == F7_ADD) begin
          k = OP_ADD;
        end else if (instr[14:12] == F3_ADD && instr[31:25] == F7_SUB) begin
          k = OP_SUB;
        end else begin
          k = OP_ILLEGAL;
        end
      end
      default: k = OP_ILLEGAL;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/control_unit_if.sv
// Instruction-fetch handshake and datapath control bundle; master = control unit, slave = memory/datapath side.
interface control_unit_if #(
  parameter int WORDSIZE = 64
);
  logic [WORDSIZE-1:0] cu_pc;
  logic [31:0]         cu_instr;
  logic                cu_instr_valid;
  logic                cu_instr_ready;
  logic [4:0]          cu_rf_addr_a;
  logic [4:0]          cu_rf_addr_b;
  logic [4:0]          cu_rf_write_addr;
  logic                cu_rf_write_en;
  logic [WORDSIZE-1:0] cu_immediate;
  logic                cu_mux_0_sel;
  logic                cu_mux_1_sel;
  logic                cu_mux_2_sel;
  logic [2:0]          cu_alu_operation;
  logic                cu_dm_write_en;
  logic                cu_illegal;

  modport master (
    input  cu_instr, cu_instr_valid,
    output cu_pc, cu_instr_ready, cu_rf_addr_a, cu_rf_addr_b, cu_rf_write_addr,
           cu_rf_write_en, cu_immediate, cu_mux_0_sel, cu_mux_1_sel, cu_mux_2_sel,
           cu_alu_operation, cu_dm_write_en, cu_illegal
  );

  modport slave (
    output cu_instr, cu_instr_valid,
    input  cu_pc, cu_instr_ready, cu_rf_addr_a, cu_rf_addr_b, cu_rf_write_addr,
           cu_rf_write_en, cu_immediate, cu_mux_0_sel, cu_mux_1_sel, cu_mux_2_sel,
           cu_alu_operation, cu_dm_write_en, cu_illegal
  );
endinterface

// File: rtl/control_unit_imm_gen.sv
// cu_imm_gen: combinational sign extension of I- and S-format immediates; other formats yield zero.
module cu_imm_gen
  import riscv_ctrl_pkg::*;
#(
  parameter int WORDSIZE = 64
) (
  input  logic [11:0]         imm_hi_i,   // instr[31:20]
  input  logic [4:0]          imm_lo_i,   // instr[11:7]
  input  imm_fmt_e            fmt_i,
  output logic [WORDSIZE-1:0] imm_o
);

  // Select and sign-extend the immediate field for the decoded format.
  always_comb begin
    imm_o = '0;
    case (fmt_i)
      IMM_I:   imm_o = {{(WORDSIZE-12){imm_hi_i[11]}}, imm_hi_i};
      IMM_S:   imm_o = {{(WORDSIZE-12){imm_hi_i[11]}}, imm_hi_i[11:5], imm_lo_i};
      default: imm_o = '0;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Multicycle control FSM: fetch handshake, decode, EXECUTE/MEM/WRITEBACK sequencing and PC ownership.
// Optional CONTROL_UNIT_PERF_CNT_EN adds cycle and retired-instruction counters.
module control_unit
  import riscv_ctrl_pkg::*;
#(
  parameter int WORDSIZE = 64
) (
  input  logic                 cu_clk,
  input  logic                 cu_rst_n,
  control_unit_if.master       bus
`ifdef CONTROL_UNIT_PERF_CNT_EN
  ,
  output logic [63:0]          cu_cycle_count,
  output logic [63:0]          cu_retired_count
`endif
);

  cu_state_e           state_q;
  op_kind_e            op_q;
  logic [WORDSIZE-1:0] pc_q;
  logic                ready_q, rf_we_q, dm_we_q, illegal_q;
  logic [4:0]          addr_a_q, addr_b_q, waddr_q;
  logic [WORDSIZE-1:0] imm_q;
  logic                mux0_q, mux1_q, mux2_q;
  logic [2:0]          alu_q;

  op_kind_e            op_d;
  imm_fmt_e            fmt_d;
  logic [4:0]          addr_a_d, addr_b_d, waddr_d;
  logic [WORDSIZE-1:0] imm_d;
  logic                mux0_d, mux1_d, mux2_d;
  logic [2:0]          alu_d;

  cu_imm_gen #(.WORDSIZE(WORDSIZE)) u_imm_gen (
    .imm_hi_i (bus.cu_instr[31:20]),
    .imm_lo_i (bus.cu_instr[11:7]),
    .fmt_i    (fmt_d),
    .imm_o    (imm_d)
  );

  // Decode the presented word so controls are already valid in the DECODE cycle.
  always_comb begin
    op_d     = classify(bus.cu_instr);
    fmt_d    = IMM_NONE;
    addr_a_d = 5'd0;
    addr_b_d = 5'd0;
    waddr_d  = 5'd0;
    mux0_d   = MUX0_RF_A;
    mux1_d   = MUX1_IMM;
    mux2_d   = MUX2_ALU;
    alu_d    = ALU_ADD;
    case (op_d)
      OP_LD: begin
        addr_a_d = bus.cu_instr[19:15];
        waddr_d  = bus.cu_instr[11:7];
        fmt_d    = IMM_I;
        mux2_d   = MUX2_DM;
      end
      OP_SD: begin
        addr_a_d = bus.cu_instr[24:20];
        addr_b_d = bus.cu_instr[19:15];
        fmt_d    = IMM_S;
        mux0_d   = MUX0_RF_B;
      end
      OP_ADDI: begin
        addr_a_d = bus.cu_instr[19:15];
        waddr_d  = bus.cu_instr[11:7];
        fmt_d    = IMM_I;
      end
      OP_ADD, OP_SUB: begin
        addr_a_d = bus.cu_instr[19:15];
        addr_b_d = bus.cu_instr[24:20];
        waddr_d  = bus.cu_instr[11:7];
        mux1_d   = MUX1_RF_B;
        alu_d    = (op_d == OP_SUB) ? ALU_SUB : ALU_ADD;
      end
      default: fmt_d = IMM_NONE;
    endcase
  end

  // Sequencer: state, PC, decoded-control registers and the two strobes.
  always_ff @(posedge cu_clk or negedge cu_rst_n) begin
    if (!cu_rst_n) begin
      state_q   <= ST_FETCH;
      op_q      <= OP_ILLEGAL;
      pc_q      <= '0;
      ready_q   <= 1'b1;
      rf_we_q   <= 1'b0;
      dm_we_q   <= 1'b0;
      illegal_q <= 1'b0;
      addr_a_q  <= 5'd0;
      addr_b_q  <= 5'd0;
      waddr_q   <= 5'd0;
      imm_q     <= '0;
      mux0_q    <= 1'b0;
      mux1_q    <= 1'b0;
      mux2_q    <= 1'b0;
      alu_q     <= 3'd0;
    end else begin
      case (state_q)
        ST_FETCH: begin
          if (bus.cu_instr_valid) begin
            state_q   <= ST_DECODE;
            ready_q   <= 1'b0;
            op_q      <= op_d;
            illegal_q <= (op_d == OP_ILLEGAL);
            addr_a_q  <= addr_a_d;
            addr_b_q  <= addr_b_d;
            waddr_q   <= waddr_d;
            imm_q     <= imm_d;
            mux0_q    <= mux0_d;
            mux1_q    <= mux1_d;
            mux2_q    <= mux2_d;
            alu_q     <= alu_d;
          end else begin
            ready_q <= 1'b1;
          end
        end
        ST_DECODE: begin
          illegal_q <= 1'b0;
          if (op_q == OP_ILLEGAL) begin
            state_q <= ST_FETCH;
            ready_q <= 1'b1;
            pc_q    <= pc_q + WORDSIZE'(4);
          end else begin
            state_q <= ST_EXECUTE;
          end
        end
        ST_EXECUTE: begin
          if (op_q == OP_LD || op_q == OP_SD) begin
            state_q <= ST_MEM;
            dm_we_q <= (op_q == OP_SD);
          end else begin
            state_q <= ST_WRITEBACK;
            rf_we_q <= (waddr_q != 5'd0);
          end
        end
        ST_MEM: begin
          dm_we_q <= 1'b0;
          if (op_q == OP_LD) begin
            state_q <= ST_WRITEBACK;
            rf_we_q <= (waddr_q != 5'd0);
          end else begin
            state_q <= ST_FETCH;
            ready_q <= 1'b1;
            pc_q    <= pc_q + WORDSIZE'(4);
          end
        end
        ST_WRITEBACK: begin
          rf_we_q <= 1'b0;
          state_q <= ST_FETCH;
          ready_q <= 1'b1;
          pc_q    <= pc_q + WORDSIZE'(4);
        end
        default: begin
          state_q   <= ST_FETCH;
          ready_q   <= 1'b1;
          rf_we_q   <= 1'b0;
          dm_we_q   <= 1'b0;
          illegal_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cu_pc            = pc_q;
  assign bus.cu_instr_ready   = ready_q;
  assign bus.cu_rf_addr_a     = addr_a_q;
  assign bus.cu_rf_addr_b     = addr_b_q;
  assign bus.cu_rf_write_addr = waddr_q;
  assign bus.cu_rf_write_en   = rf_we_q;
  assign bus.cu_immediate     = imm_q;
  assign bus.cu_mux_0_sel     = mux0_q;
  assign bus.cu_mux_1_sel     = mux1_q;
  assign bus.cu_mux_2_sel     = mux2_q;
  assign bus.cu_alu_operation = alu_q;
  assign bus.cu_dm_write_en   = dm_we_q;
  assign bus.cu_illegal       = illegal_q;

`ifdef CONTROL_UNIT_PERF_CNT_EN
  logic        retire_now;
  logic [63:0] cycle_cnt_q, retired_cnt_q;

  assign retire_now = (state_q == ST_WRITEBACK) || (state_q == ST_MEM && op_q == OP_SD);

  // Free-running cycle counter and count of non-illegal instructions retired.
  always_ff @(posedge cu_clk or negedge cu_rst_n) begin
    if (!cu_rst_n) begin
      cycle_cnt_q   <= 64'd0;
      retired_cnt_q <= 64'd0;
    end else begin
      cycle_cnt_q   <= cycle_cnt_q + 64'd1;
      retired_cnt_q <= retire_now ? retired_cnt_q + 64'd1 : retired_cnt_q;
    end
  end

  assign cu_cycle_count   = cycle_cnt_q;
  assign cu_retired_count = retired_cnt_q;
`endif

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: directed cases plus random instruction stream against a latency/decode model.
module tb_control_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  control_unit_if #(.WORDSIZE(64)) bus ();

`ifdef CONTROL_UNIT_PERF_CNT_EN
  logic [63:0] cyc_cnt, ret_cnt;
`endif

  control_unit #(.WORDSIZE(64)) dut (
    .cu_clk   (clk),
    .cu_rst_n (rst_n),
    .bus      (bus.master)
`ifdef CONTROL_UNIT_PERF_CNT_EN
    ,
    .cu_cycle_count   (cyc_cnt),
    .cu_retired_count (ret_cnt)
`endif
  );

  int          n_vec = 0;
  int          n_bad = 0;
  logic [63:0] pc_model = 64'd0;
  longint      retired_model = 0;

  typedef struct {
    int          kind;     // 0 illegal, 1 ld, 2 sd, 3 addi, 4 add, 5 sub
    int          lat;      // cycles from handshake to next ready
    int          rf_cyc;   // cycle index of the rf write pulse, -1 if none
    int          dm_cyc;   // cycle index of the dm write pulse, -1 if none
    logic [4:0]  a, b, wa;
    logic [63:0] imm;
    logic        m0, m1, m2;
    logic [2:0]  alu;
    bit          care_b, care_wa, care_m2;
  } exp_t;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [31:0] w);
    exp_t e;
    logic signed [11:0] i12, s12;
    logic signed [63:0] wide;
    int opc, f3, f7;
    opc = int'(w[6:0]); f3 = int'(w[14:12]); f7 = int'(w[31:25]);
    i12 = w[31:20];
    s12 = {w[31:25], w[11:7]};
    e = '{kind: 0, lat: 2, rf_cyc: -1, dm_cyc: -1, a: 5'd0, b: 5'd0, wa: 5'd0, imm: 64'd0,
          m0: 1'b0, m1: 1'b0, m2: 1'b0, alu: 3'd0, care_b: 1'b0, care_wa: 1'b0, care_m2: 1'b0};
    if (opc == 3 && f3 == 3) begin
      e.kind = 1; e.lat = 5; e.a = w[19:15]; e.wa = w[11:7]; wide = i12; e.imm = wide;
      e.m2 = 1'b1; e.care_wa = 1'b1; e.care_m2 = 1'b1;
      e.rf_cyc = (w[11:7] != 5'd0) ? 4 : -1;
    end else if (opc == 35 && f3 == 3) begin
      e.kind = 2; e.lat = 4; e.a = w[24:20]; e.b = w[19:15]; wide = s12; e.imm = wide;
      e.m0 = 1'b1; e.care_b = 1'b1; e.dm_cyc = 3;
    end else if (opc == 19 && f3 == 0) begin
      e.kind = 3; e.lat = 4; e.a = w[19:15]; e.wa = w[11:7]; wide = i12; e.imm = wide;
      e.care_wa = 1'b1; e.care_m2 = 1'b1;
      e.rf_cyc = (w[11:7] != 5'd0) ? 3 : -1;
    end else if (opc == 51 && f3 == 0 && (f7 == 0 || f7 == 32)) begin
      e.kind = (f7 == 0) ? 4 : 5; e.lat = 4; e.a = w[19:15]; e.b = w[24:20]; e.wa = w[11:7];
      e.m1 = 1'b1; e.alu = (f7 == 0) ? 3'd0 : 3'd1;
      e.care_b = 1'b1; e.care_wa = 1'b1; e.care_m2 = 1'b1;
      e.rf_cyc = (w[11:7] != 5'd0) ? 3 : -1;
    end
    return e;
  endfunction

  task automatic check_controls(input exp_t e);
    chk("addr_a", bus.cu_rf_addr_a, e.a);
    if (e.care_b) chk("addr_b", bus.cu_rf_addr_b, e.b);
    if (e.care_wa) chk("write_addr", bus.cu_rf_write_addr, e.wa);
    chk("immediate", bus.cu_immediate, e.imm);
    chk("mux0", bus.cu_mux_0_sel, e.m0);
    chk("mux1", bus.cu_mux_1_sel, e.m1);
    if (e.care_m2) chk("mux2", bus.cu_mux_2_sel, e.m2);
    chk("alu_op", bus.cu_alu_operation, e.alu);
  endtask

  task automatic wait_ready();
    int waited = 0;
    while (bus.cu_instr_ready !== 1'b1 && waited < 16) begin
      @(posedge clk); #1;
      waited++;
    end
    chk("fetch_ready", bus.cu_instr_ready, 1'b1);
    chk("fetch_pc", bus.cu_pc, pc_model);
  endtask

  task automatic handshake(input logic [31:0] w);
    bus.cu_instr = w;
    bus.cu_instr_valid = 1'b1;
    @(posedge clk); #1;
    bus.cu_instr_valid = 1'b0;
    bus.cu_instr = $urandom();
  endtask

  task automatic run_instr(input logic [31:0] w);
    exp_t e;
    e = model(w);
    wait_ready();
    handshake(w);
    for (int c = 1; c <= e.lat; c++) begin
      chk("instr_ready", bus.cu_instr_ready, (c == e.lat));
      chk("rf_write_en", bus.cu_rf_write_en, (c == e.rf_cyc));
      chk("dm_write_en", bus.cu_dm_write_en, (c == e.dm_cyc));
      chk("illegal", bus.cu_illegal, (e.kind == 0 && c == 1));
      chk("pc", bus.cu_pc, (c == e.lat) ? pc_model + 64'd4 : pc_model);
      if (e.kind != 0 && c < e.lat) check_controls(e);
      if (c < e.lat) begin
        @(posedge clk); #1;
      end
    end
    pc_model = pc_model + 64'd4;
    if (e.kind != 0) retired_model++;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [4:0]  rs1, rs2, rd;
    logic [11:0] imm;
    logic [31:0] w;
    rs1 = 5'($urandom()); rs2 = 5'($urandom()); rd = 5'($urandom()); imm = 12'($urandom());
    case ($urandom_range(0, 5))
      0: w = {imm, rs1, 3'b011, rd, 7'b0000011};
      1: w = {imm[11:5], rs2, rs1, 3'b011, imm[4:0], 7'b0100011};
      2: w = {imm, rs1, 3'b000, rd, 7'b0010011};
      3: w = {7'b0000000, rs2, rs1, 3'b000, rd, 7'b0110011};
      4: w = {7'b0100000, rs2, rs1, 3'b000, rd, 7'b0110011};
      default: w = $urandom();
    endcase
    return w;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.cu_instr = 32'd0;
    bus.cu_instr_valid = 1'b0;
    #12;
    chk("rst_pc", bus.cu_pc, 64'd0);
    chk("rst_ready", bus.cu_instr_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("idle_ready", bus.cu_instr_ready, 1'b1);
      chk("idle_pc", bus.cu_pc, 64'd0);
      chk("idle_strobes", {bus.cu_rf_write_en, bus.cu_dm_write_en, bus.cu_illegal}, 3'b000);
      chk("idle_ctrl", {bus.cu_rf_addr_a, bus.cu_rf_addr_b, bus.cu_alu_operation, bus.cu_mux_2_sel}, 18'd0);
      chk("idle_imm", bus.cu_immediate, 64'd0);
    end

    // Directed: ld, sd, add, sub, illegal, addi to x0
    run_instr(32'h0053B103);
    run_instr(32'h00413BA3);
    run_instr(32'h000100B3);
    run_instr(32'h402000B3);
    run_instr(32'hFFFFFFFF);
    run_instr(32'h00100013);

    for (int n = 0; n < 150; n++) begin
      int gap;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        @(posedge clk); #1;
        chk("gap_ready", bus.cu_instr_ready, 1'b1);
        chk("gap_pc", bus.cu_pc, pc_model);
      end
      run_instr(rand_instr());
    end

`ifdef CONTROL_UNIT_PERF_CNT_EN
    chk("retired_count", ret_cnt, 64'(retired_model));
`endif

    // Reset during the MEM cycle of an ld with rd != 0
    wait_ready();
    handshake(32'h0053B103);
    repeat (2) begin
      @(posedge clk); #1;
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst_pc", bus.cu_pc, 64'd0);
    chk("mrst_ready", bus.cu_instr_ready, 1'b1);
    chk("mrst_strobes", {bus.cu_rf_write_en, bus.cu_dm_write_en, bus.cu_illegal}, 3'b000);
    chk("mrst_ctrl", {bus.cu_rf_addr_a, bus.cu_rf_write_addr, bus.cu_mux_2_sel}, 11'd0);
    chk("mrst_imm", bus.cu_immediate, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    pc_model = 64'd0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("post_rst_rf_we", bus.cu_rf_write_en, 1'b0);
      chk("post_rst_ready", bus.cu_instr_ready, 1'b1);
      chk("post_rst_pc", bus.cu_pc, 64'd0);
    end
    run_instr(32'h00500093);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
